// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
package mem_pkg;

  // Access size encodings on MemSize; 2'd3 is treated as a word.
  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;

  // Default number of BUSY cycles before a bus error is raised.
  localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_load_ext.sv
// Load lane select and sign/zero extension (purely combinational).
module mem_load_ext
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] data_o
);

  logic [7:0]  lane8;
  logic [15:0] lane16;

  // Pick the addressed byte and halfword out of the read word.
  always_comb begin
    lane8 = rdata_i[7:0];
    unique case (addr_lo_i)
      2'd0: lane8 = rdata_i[7:0];
      2'd1: lane8 = rdata_i[15:8];
      2'd2: lane8 = rdata_i[23:16];
      2'd3: lane8 = rdata_i[31:24];
      default: lane8 = rdata_i[7:0];
    endcase
    lane16 = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Extend the selected lane to 32 bits; word loads pass through.
  always_comb begin
    data_o = rdata_i;
    if (size_i == MEM_SIZE_B) begin
      data_o = {{24{signed_i & lane8[7]}}, lane8};
    end else if (size_i == MEM_SIZE_H) begin
      data_o = {{16{signed_i & lane16[15]}}, lane16};
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: EX/MEM controls -> req/ready data bus, with
// pipeline stall and a held load result for WB.
// Optional bus timeout enabled by defining DMEM_TIMEOUT_EN.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_MEM_ctrl_MemRead,
  input  logic              i_MEM_ctrl_MemWrite,
  input  logic [1:0]        i_MEM_ctrl_MemSize,
  input  logic              i_MEM_ctrl_MemSigned,
  input  logic [ADDR_W-1:0] i_MEM_data_Addr,
  input  logic [31:0]       i_MEM_data_WrData,
  output logic [31:0]       o_WB_data_MemData,
  output logic              o_stall,
  output logic              o_misalign,
  output logic              o_bus_err,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic [3:0]        o_dmem_be,
  output logic [31:0]       o_dmem_wdata,
  input  logic              i_dmem_ready,
  input  logic [31:0]       i_dmem_rdata
);

  mem_state_e        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       hold_q, hold_d;
  // Load attributes captured at issue, used when the read data returns.
  logic              load_q, load_d;
  logic [1:0]        lo_q, lo_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;

  logic              access;
  logic              misaligned;
  logic [3:0]        be_fmt;
  logic [31:0]       wdata_fmt;
  logic [31:0]       ext_data;

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            bus_err_q, bus_err_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  mem_load_ext u_load_ext (
    .rdata_i   (i_dmem_rdata),
    .addr_lo_i (lo_q),
    .size_i    (size_q),
    .signed_i  (sgn_q),
    .data_o    (ext_data)
  );

  // Decode the incoming access: alignment, byte enables and lane-replicated data.
  always_comb begin
    access     = i_MEM_ctrl_MemRead | i_MEM_ctrl_MemWrite;
    misaligned = ((i_MEM_ctrl_MemSize == MEM_SIZE_H) & i_MEM_data_Addr[0]) |
                 (i_MEM_ctrl_MemSize[1] & (i_MEM_data_Addr[1:0] != 2'b00));
    if (i_MEM_ctrl_MemSize == MEM_SIZE_B) begin
      be_fmt    = 4'b0001 << i_MEM_data_Addr[1:0];
      wdata_fmt = {4{i_MEM_data_WrData[7:0]}};
    end else if (i_MEM_ctrl_MemSize == MEM_SIZE_H) begin
      be_fmt    = i_MEM_data_Addr[1] ? 4'b1100 : 4'b0011;
      wdata_fmt = {2{i_MEM_data_WrData[15:0]}};
    end else begin
      be_fmt    = 4'b1111;
      wdata_fmt = i_MEM_data_WrData;
    end
  end

  // Next-state logic and stall/misalign outputs.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    hold_d     = hold_q;
    load_d     = load_q;
    lo_d       = lo_q;
    size_d     = size_q;
    sgn_d      = sgn_q;
    o_stall    = 1'b0;
    o_misalign = 1'b0;
`ifdef DMEM_TIMEOUT_EN
    cnt_d      = cnt_q;
    bus_err_d  = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        o_misalign = access & misaligned;
        o_stall    = access & ~misaligned;
        if (access & ~misaligned) begin
          state_d = StBusy;
          req_d   = 1'b1;
          // Write wins when both controls are set.
          we_d    = i_MEM_ctrl_MemWrite;
          load_d  = ~i_MEM_ctrl_MemWrite;
          addr_d  = {i_MEM_data_Addr[ADDR_W-1:2], 2'b00};
          be_d    = be_fmt;
          wdata_d = wdata_fmt;
          lo_d    = i_MEM_data_Addr[1:0];
          size_d  = i_MEM_ctrl_MemSize;
          sgn_d   = i_MEM_ctrl_MemSigned;
`ifdef DMEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      StBusy: begin
        o_stall = 1'b1;
        if (i_dmem_ready) begin
          req_d   = 1'b0;
          state_d = StDone;
          if (load_q) begin
            hold_d = ext_data;
          end
`ifdef DMEM_TIMEOUT_EN
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          req_d     = 1'b0;
          bus_err_d = 1'b1;
          state_d   = StDone;
          if (load_q) begin
            hold_d = 32'h0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and bus registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= 4'b0000;
      wdata_q   <= 32'h0;
      hold_q    <= 32'h0;
      load_q    <= 1'b0;
      lo_q      <= 2'b00;
      size_q    <= MEM_SIZE_B;
      sgn_q     <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      hold_q    <= hold_d;
      load_q    <= load_d;
      lo_q      <= lo_d;
      size_q    <= size_d;
      sgn_q     <= sgn_d;
`ifdef DMEM_TIMEOUT_EN
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
`endif
    end
  end

  assign o_WB_data_MemData = hold_q;
  assign o_dmem_req        = req_q;
  assign o_dmem_we         = we_q;
  assign o_dmem_addr       = addr_q;
  assign o_dmem_be         = be_q;
  assign o_dmem_wdata      = wdata_q;
`ifdef DMEM_TIMEOUT_EN
  assign o_bus_err         = bus_err_q;
`else
  assign o_bus_err         = 1'b0;
`endif

endmodule
